// File: rtl/scc_pkg.sv
// Shared decode constants, state encoding and small decode helpers for the SCC control sequencer.
package scc_pkg;

  localparam logic [1:0] CLS_DIMM = 2'b00;
  localparam logic [1:0] CLS_DREG = 2'b01;
  localparam logic [1:0] CLS_LS   = 2'b10;
  localparam logic [1:0] CLS_SYS  = 2'b11;

  localparam logic [3:0] OP_B     = 4'b0000;
  localparam logic [3:0] OP_BCOND = 4'b0001;
  localparam logic [3:0] OP_BR    = 4'b0010;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  function automatic logic is_halt(input logic [1:0] cls, input logic [3:0] op);
    return (cls == CLS_SYS) && op[3] && !op[2];
  endfunction

  // Condition mask is ordered N,Z,C,V; any selected flag that is set takes the branch.
  function automatic logic cond_taken(input logic [3:0] mask, input logic [3:0] nzcv);
    return (mask[FLAG_N] & nzcv[FLAG_N]) | (mask[FLAG_Z] & nzcv[FLAG_Z]) |
           (mask[FLAG_C] & nzcv[FLAG_C]) | (mask[FLAG_V] & nzcv[FLAG_V]);
  endfunction

endpackage

// File: rtl/scc_control_fsm_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and memory side (slave).
interface scc_control_fsm_if;
  logic imem_req;
  logic imem_valid;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_valid, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_valid, dmem_ready);
endinterface

// File: rtl/scc_wait_timer.sv
// Handshake wait counter: counts unsatisfied cycles and flags when the timeout count is reached.
module scc_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= '0;
    else if (clr)              count <= '0;
    else if (en && !expired)   count <= count + 1'b1;
  end

endmodule

// File: rtl/scc_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the SCC core.
module scc_control_fsm
  import scc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TO_W           = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               first_ld,
  input  logic [3:0]               second_ld,
  input  logic                     special_enc,
  input  logic [3:0]               b_cond,
  input  logic                     ls_store,
  input  logic [3:0]               flags,
  scc_control_fsm_if.master        mem,
  output logic                     ir_load,
  output logic                     pc_inc,
  output logic                     pc_write,
  output logic                     pc_sel,
  output logic                     reg_we,
  output logic                     wb_sel,
  output logic                     flag_we,
  output logic [2:0]               state_o,
  output logic                     halted,
  output logic                     fault
);

  state_t state, state_nxt;
  logic   wait_en, expired;

  // The counter only runs while a handshake is pending, so it is zero on every entry to FETCH/MEM.
  assign wait_en = ((state == ST_FETCH) && !mem.imem_valid) ||
                   ((state == ST_MEM)   && !mem.dmem_ready);

  scc_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!wait_en),
    .en     (wait_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (mem.imem_valid) state_nxt = ST_DECODE;
        else if (expired)   state_nxt = ST_FAULT;
      end
      ST_DECODE: state_nxt = is_halt(first_ld, second_ld) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (first_ld)
          CLS_DIMM, CLS_DREG: state_nxt = ST_WB;
          CLS_LS:             state_nxt = ST_MEM;
          default:            state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ready) state_nxt = ls_store ? ST_FETCH : ST_WB;
        else if (expired)   state_nxt = ST_FAULT;
      end
      ST_WB:    state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FAULT;
    endcase
  end

  // Strobes are forced low while reset is asserted, including the FETCH request.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    flag_we      = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem.imem_req = 1'b1;
          ir_load      = mem.imem_valid;
          pc_inc       = mem.imem_valid;
        end
        ST_EXEC: begin
          if (first_ld == CLS_SYS) begin
            case (second_ld)
              OP_B:     pc_write = 1'b1;
              OP_BCOND: pc_write = cond_taken(b_cond, flags);
              OP_BR: begin
                pc_write = 1'b1;
                pc_sel   = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = ls_store;
        end
        ST_WB: begin
          reg_we  = 1'b1;
          wb_sel  = (first_ld == CLS_LS);
          flag_we = special_enc & second_ld[3];
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;
  assign halted  = (state == ST_HALT) || (state == ST_FAULT);
  assign fault   = (state == ST_FAULT);

endmodule
